// File: rtl/io_bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | io_bus_pkg                                                                 |
// | Shared types and constants for the HPS I/O bus target controller.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package io_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_ACK     = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   localparam int         NUM_TARGETS  = 3;
   localparam logic [1:0] REGION_REGS  = 2'b11;

   localparam logic [1:0] OFF_IRQ_PEND = 2'd0;
   localparam logic [1:0] OFF_IRQ_MASK = 2'd1;
   localparam logic [1:0] OFF_TO_ADDR  = 2'd2;

   function automatic logic [NUM_TARGETS-1:0] region_onehot(input logic [1:0] region);
      logic [NUM_TARGETS-1:0] sel;
      case (region)
         2'd0:    sel = 3'b001;
         2'd1:    sel = 3'b010;
         2'd2:    sel = 3'b100;
         default: sel = 3'b000;
      endcase
      return sel;
   endfunction

endpackage
`default_nettype wire

// File: rtl/io_bus_regs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | io_bus_regs                                                                |
// | Internal register bank: IRQ mask, sticky timeout pending, timeout address. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module io_bus_regs
   import io_bus_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   wr_en,
   input  logic [1:0]             offset,
   input  logic                   lane0_en,
   input  logic [3:0]             write_data,
   output logic [15:0]            read_data,
   input  logic [NUM_TARGETS-1:0] tgt_irq,
   input  logic                   to_set,
   input  logic [15:0]            to_addr_in,
   output logic                   irq
);

   logic [3:0]  r_mask;
   logic        r_to_pend;
   logic [15:0] r_to_addr;
   logic        r_irq;
   logic        w_mask_wr;
   logic        w_pend_clr;

   // Only the low byte lane holds writable bits, so lane 0 gates every write.
   assign w_mask_wr  = wr_en && (offset == OFF_IRQ_MASK) && lane0_en;
   assign w_pend_clr = wr_en && (offset == OFF_IRQ_PEND) && lane0_en && write_data[3];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mask    <= 4'h0;
         r_to_pend <= 1'b0;
         r_to_addr <= 16'h0000;
         r_irq     <= 1'b0;
      end else begin
         if (w_mask_wr)
            r_mask <= write_data;
         if (to_set) begin
            r_to_pend <= 1'b1;
            r_to_addr <= to_addr_in;
         end else if (w_pend_clr) begin
            r_to_pend <= 1'b0;
         end
         r_irq <= |({r_to_pend, tgt_irq} & r_mask);
      end
   end

   always_comb begin
      read_data = 16'h0000;
      case (offset)
         OFF_IRQ_PEND: read_data[3:0] = {r_to_pend, tgt_irq};
         OFF_IRQ_MASK: read_data[3:0] = r_mask;
         OFF_TO_ADDR:  read_data      = r_to_addr;
         default:      read_data      = 16'h0000;
      endcase
   end

   assign irq = r_irq;

endmodule
`default_nettype wire

// File: rtl/io_bus_target_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | io_bus_target_ctrl                                                         |
// | Decodes the HPS I/O bridge onto three targets plus a register bank.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module io_bus_target_ctrl
   import io_bus_pkg::*;
#(
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [15:0] TIMEOUT_RDATA  = 16'hDEAD
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [15:0]              io_address,
   input  logic                     io_bus_enable,
   input  logic                     io_rw,
   input  logic [1:0]               io_byte_enable,
   input  logic [15:0]              io_write_data,
   output logic [15:0]              io_read_data,
   output logic                     io_acknowledge,
   output logic                     io_irq,
   output logic [NUM_TARGETS-1:0]   tgt_sel,
   output logic [13:0]              tgt_address,
   output logic                     tgt_rw,
   output logic [1:0]               tgt_byte_enable,
   output logic [15:0]              tgt_write_data,
   input  logic [16*NUM_TARGETS-1:0] tgt_read_data,
   input  logic [NUM_TARGETS-1:0]   tgt_ack,
   input  logic [NUM_TARGETS-1:0]   tgt_irq
);

   localparam logic [15:0] c_timeout = 16'(TIMEOUT_CYCLES);

   state_t      r_state;
   logic [15:0] r_count;
   logic [1:0]  r_region;

   logic [15:0] w_reg_rdata;
   logic [15:0] w_tgt_rdata;
   logic        w_reg_wr;
   logic        w_sel_ack;
   logic        w_expire;
   logic        w_to_set;

   assign w_reg_wr  = (r_state == ST_IDLE) && io_bus_enable &&
                      (io_address[15:14] == REGION_REGS) && !io_rw;
   assign w_sel_ack = |(tgt_ack & tgt_sel);
   assign w_expire  = (r_state == ST_ACCESS) && (r_count == c_timeout);
   // A target acknowledge in the expiry cycle still completes the access normally.
   assign w_to_set  = w_expire && !w_sel_ack;

   always_comb begin
      w_tgt_rdata = 16'h0000;
      case (r_region)
         2'd0:    w_tgt_rdata = tgt_read_data[15:0];
         2'd1:    w_tgt_rdata = tgt_read_data[31:16];
         2'd2:    w_tgt_rdata = tgt_read_data[47:32];
         default: w_tgt_rdata = 16'h0000;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state         <= ST_IDLE;
         r_count         <= 16'h0000;
         r_region        <= 2'd0;
         io_read_data    <= 16'h0000;
         io_acknowledge  <= 1'b0;
         tgt_sel         <= '0;
         tgt_address     <= 14'h0000;
         tgt_rw          <= 1'b0;
         tgt_byte_enable <= 2'b00;
         tgt_write_data  <= 16'h0000;
      end else begin
         io_acknowledge <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (io_bus_enable) begin
                  if (io_address[15:14] == REGION_REGS) begin
                     io_read_data   <= io_rw ? w_reg_rdata : 16'h0000;
                     io_acknowledge <= 1'b1;
                     r_state        <= ST_ACK;
                  end else begin
                     r_region        <= io_address[15:14];
                     tgt_address     <= io_address[13:0];
                     tgt_rw          <= io_rw;
                     tgt_byte_enable <= io_byte_enable;
                     tgt_write_data  <= io_write_data;
                     tgt_sel         <= region_onehot(io_address[15:14]);
                     r_count         <= 16'h0000;
                     r_state         <= ST_ACCESS;
                  end
               end
            end
            ST_ACCESS: begin
               if (w_sel_ack) begin
                  io_read_data   <= tgt_rw ? w_tgt_rdata : 16'h0000;
                  io_acknowledge <= 1'b1;
                  tgt_sel        <= '0;
                  r_state        <= ST_ACK;
               end else if (w_expire) begin
                  io_read_data   <= tgt_rw ? TIMEOUT_RDATA : 16'h0000;
                  io_acknowledge <= 1'b1;
                  tgt_sel        <= '0;
                  r_state        <= ST_ACK;
               end else begin
                  r_count <= r_count + 16'd1;
               end
            end
            ST_ACK: begin
               r_state <= ST_RELEASE;
            end
            ST_RELEASE: begin
               if (!io_bus_enable)
                  r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   io_bus_regs u_regs (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_en      (w_reg_wr),
      .offset     (io_address[1:0]),
      .lane0_en   (io_byte_enable[0]),
      .write_data (io_write_data[3:0]),
      .read_data  (w_reg_rdata),
      .tgt_irq    (tgt_irq),
      .to_set     (w_to_set),
      .to_addr_in ({r_region, tgt_address}),
      .irq        (io_irq)
   );

endmodule
`default_nettype wire

// File: tb/tb_io_bus_target_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_io_bus_target_ctrl                                                      |
// | Vector table, corner sequences and randomized accesses vs a bus model.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_io_bus_target_ctrl;

   localparam int T = 8;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] io_address;
   logic        io_bus_enable;
   logic        io_rw;
   logic [1:0]  io_byte_enable;
   logic [15:0] io_write_data;
   logic [15:0] io_read_data;
   logic        io_acknowledge;
   logic        io_irq;
   logic [2:0]  tgt_sel;
   logic [13:0] tgt_address;
   logic        tgt_rw;
   logic [1:0]  tgt_byte_enable;
   logic [15:0] tgt_write_data;
   logic [47:0] tgt_read_data;
   logic [2:0]  tgt_ack;
   logic [2:0]  tgt_irq;

   int checks   = 0;
   int failures = 0;

   // Reference state of the register bank
   logic [3:0]  m_mask;
   logic        m_pend;
   logic [15:0] m_to_addr;

   typedef struct {
      logic [15:0] addr;
      logic        rw;
      logic [1:0]  be;
      logic [15:0] wdata;
      int          delay;
      logic [15:0] trdata;
      logic        chk_rd;
      logic [15:0] exp_rd;
      int          exp_lat;
   } vec_t;

   vec_t        vecs[$];
   logic [15:0] got_rd;
   int          got_lat;
   int          episodes;
   int          acks;
   logic        prev_sel;
   logic [15:0] r_addr;
   logic        r_rw;
   logic [1:0]  r_be;
   logic [15:0] r_wdata;
   logic [15:0] r_trdata;
   logic [15:0] r_exp_rd;
   int          r_delay;
   int          r_exp_lat;
   int          r_pick;
   int          r_region;

   always #5 clk = ~clk;

   io_bus_target_ctrl #(
      .TIMEOUT_CYCLES (T),
      .TIMEOUT_RDATA  (16'hDEAD)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .io_address      (io_address),
      .io_bus_enable   (io_bus_enable),
      .io_rw           (io_rw),
      .io_byte_enable  (io_byte_enable),
      .io_write_data   (io_write_data),
      .io_read_data    (io_read_data),
      .io_acknowledge  (io_acknowledge),
      .io_irq          (io_irq),
      .tgt_sel         (tgt_sel),
      .tgt_address     (tgt_address),
      .tgt_rw          (tgt_rw),
      .tgt_byte_enable (tgt_byte_enable),
      .tgt_write_data  (tgt_write_data),
      .tgt_read_data   (tgt_read_data),
      .tgt_ack         (tgt_ack),
      .tgt_irq         (tgt_irq)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [15:0] addr, input logic rw, input logic [1:0] be,
                               input logic [15:0] wdata, input int delay, input logic [15:0] trdata,
                               input logic chk_rd, input logic [15:0] exp_rd, input int exp_lat);
      vec_t v;
      v.addr = addr; v.rw = rw; v.be = be; v.wdata = wdata; v.delay = delay;
      v.trdata = trdata; v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_lat = exp_lat;
      return v;
   endfunction

   function automatic logic [15:0] model_read(input logic [1:0] off);
      case (off)
         2'd0:    return {12'h000, m_pend, tgt_irq};
         2'd1:    return {12'h000, m_mask};
         2'd2:    return m_to_addr;
         default: return 16'h0000;
      endcase
   endfunction

   function automatic logic model_irq();
      return |({m_pend, tgt_irq} & m_mask);
   endfunction

   function automatic bit times_out(input int delay);
      return (delay < 0) || (delay > T);
   endfunction

   function automatic int exp_latency(input logic [15:0] addr, input int delay);
      if (addr[15:14] == 2'b11) return 1;
      if (!times_out(delay))    return delay + 2;
      return T + 2;
   endfunction

   // One bridge access: delay = cycles after select before the target acks, <0 = never.
   task automatic do_access(input logic [15:0] addr, input logic rw, input logic [1:0] be,
                            input logic [15:0] wdata, input int delay, input logic [15:0] trdata,
                            output logic [15:0] rdata, output int lat);
      logic [2:0]  sel;
      logic [47:0] rd;
      int          sel_bad;
      bit          got;
      sel = (addr[15:14] == 2'b11) ? 3'b000 : (3'b001 << addr[15:14]);
      io_address = addr; io_rw = rw; io_byte_enable = be; io_write_data = wdata;
      io_bus_enable = 1'b1;
      tgt_ack = 3'b000;
      tick();
      if (sel != 3'b000) begin
         chk("tgt_address", 32'(tgt_address), 32'(addr[13:0]));
         chk("tgt_rw", 32'(tgt_rw), 32'(rw));
         chk("tgt_byte_enable", 32'(tgt_byte_enable), 32'(be));
         chk("tgt_write_data", 32'(tgt_write_data), 32'(wdata));
      end
      sel_bad = 0; got = 0; lat = 0; rdata = 16'h0000;
      for (int k = 0; k <= T + 2 && !got; k++) begin
         if (io_acknowledge) begin
            got = 1;
            lat = k + 1;
         end else begin
            if (tgt_sel !== sel) sel_bad++;
            tgt_ack = 3'($urandom) & ~sel;
            if (k == delay) tgt_ack = tgt_ack | sel;
            rd = {16'($urandom), 32'($urandom)};
            if (sel != 3'b000) rd[int'(addr[15:14])*16 +: 16] = trdata;
            tgt_read_data = rd;
            tick();
         end
      end
      chk("tgt_sel_during_access", 32'(sel_bad), 32'd0);
      if (got) begin
         rdata = io_read_data;
         chk("tgt_sel_drop_at_ack", 32'(tgt_sel), 32'd0);
      end
      io_bus_enable = 1'b0;
      tgt_ack = 3'($urandom);
      tick();
      chk("ack_single_pulse", 32'(io_acknowledge), 32'd0);
      tgt_ack = 3'($urandom);
      tick();
      tgt_ack = 3'b000;
   endtask

   task automatic transact(input logic [15:0] addr, input logic rw, input logic [1:0] be,
                           input logic [15:0] wdata, input int delay, input logic [15:0] trdata,
                           output logic [15:0] rdata, output int lat);
      do_access(addr, rw, be, wdata, delay, trdata, rdata, lat);
      if (addr[15:14] == 2'b11) begin
         if (!rw && be[0]) begin
            if (addr[1:0] == 2'd1) m_mask = wdata[3:0];
            if (addr[1:0] == 2'd0 && wdata[3]) m_pend = 1'b0;
         end
      end else if (times_out(delay)) begin
         m_pend    = 1'b1;
         m_to_addr = addr;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      io_address = 16'h0000; io_bus_enable = 1'b0; io_rw = 1'b0;
      io_byte_enable = 2'b00; io_write_data = 16'h0000;
      tgt_read_data = 48'h0; tgt_ack = 3'b000; tgt_irq = 3'b000;
      m_mask = 4'h0; m_pend = 1'b0; m_to_addr = 16'h0000;

      tick(); tick();
      @(negedge clk) reset_n = 1'b1;
      tick();
      chk("reset_ack", 32'(io_acknowledge), 32'd0);
      chk("reset_sel", 32'(tgt_sel), 32'd0);
      chk("reset_irq", 32'(io_irq), 32'd0);
      chk("reset_rdata", 32'(io_read_data), 32'd0);
      chk("reset_tgt_fields", {tgt_address, tgt_rw, tgt_byte_enable, tgt_write_data}, 33'd0);

      vecs.push_back(mk(16'hC001, 1, 2'b11, 16'h0000, -1, 16'h0000, 1, 16'h0000, 1));
      vecs.push_back(mk(16'hC001, 0, 2'b11, 16'hFFFF, -1, 16'h0000, 0, 16'h0000, 1));
      vecs.push_back(mk(16'hC001, 1, 2'b11, 16'h0000, -1, 16'h0000, 1, 16'h000F, 1));
      vecs.push_back(mk(16'hC001, 0, 2'b10, 16'h0000, -1, 16'h0000, 0, 16'h0000, 1));
      vecs.push_back(mk(16'hC001, 1, 2'b11, 16'h0000, -1, 16'h0000, 1, 16'h000F, 1));
      vecs.push_back(mk(16'hC001, 0, 2'b01, 16'h0009, -1, 16'h0000, 0, 16'h0000, 1));
      vecs.push_back(mk(16'hC001, 1, 2'b11, 16'h0000, -1, 16'h0000, 1, 16'h0009, 1));
      vecs.push_back(mk(16'h4010, 0, 2'b11, 16'h1234,  3, 16'h0000, 0, 16'h0000, 5));
      vecs.push_back(mk(16'h0004, 1, 2'b11, 16'h0000,  0, 16'hA5A5, 1, 16'hA5A5, 2));
      vecs.push_back(mk(16'h8000, 1, 2'b11, 16'h0000, -1, 16'h0000, 1, 16'hDEAD, 10));
      vecs.push_back(mk(16'hC002, 1, 2'b11, 16'h0000, -1, 16'h0000, 1, 16'h8000, 1));
      vecs.push_back(mk(16'hC000, 1, 2'b11, 16'h0000, -1, 16'h0000, 1, 16'h0008, 1));
      vecs.push_back(mk(16'hC003, 0, 2'b11, 16'hFFFF, -1, 16'h0000, 0, 16'h0000, 1));
      vecs.push_back(mk(16'hC003, 1, 2'b11, 16'h0000, -1, 16'h0000, 1, 16'h0000, 1));
      vecs.push_back(mk(16'h8123, 1, 2'b11, 16'h0000,  8, 16'h5A5A, 1, 16'h5A5A, 10));
      vecs.push_back(mk(16'hC002, 1, 2'b11, 16'h0000, -1, 16'h0000, 1, 16'h8000, 1));
      vecs.push_back(mk(16'hC000, 0, 2'b10, 16'h0008, -1, 16'h0000, 0, 16'h0000, 1));
      vecs.push_back(mk(16'hC000, 1, 2'b11, 16'h0000, -1, 16'h0000, 1, 16'h0008, 1));
      vecs.push_back(mk(16'hC000, 0, 2'b01, 16'h0008, -1, 16'h0000, 0, 16'h0000, 1));
      vecs.push_back(mk(16'hC000, 1, 2'b11, 16'h0000, -1, 16'h0000, 1, 16'h0000, 1));
      vecs.push_back(mk(16'h0ABC, 0, 2'b11, 16'h1111,  9, 16'h0000, 0, 16'h0000, 10));
      vecs.push_back(mk(16'hC002, 1, 2'b11, 16'h0000, -1, 16'h0000, 1, 16'h0ABC, 1));
      vecs.push_back(mk(16'hC002, 0, 2'b11, 16'hFFFF, -1, 16'h0000, 0, 16'h0000, 1));
      vecs.push_back(mk(16'hC002, 1, 2'b11, 16'h0000, -1, 16'h0000, 1, 16'h0ABC, 1));
      vecs.push_back(mk(16'hC000, 1, 2'b11, 16'h0000, -1, 16'h0000, 1, 16'h0008, 1));

      foreach (vecs[i]) begin
         transact(vecs[i].addr, vecs[i].rw, vecs[i].be, vecs[i].wdata,
                  vecs[i].delay, vecs[i].trdata, got_rd, got_lat);
         chk($sformatf("vec%0d_latency", i), 32'(got_lat), 32'(vecs[i].exp_lat));
         if (vecs[i].chk_rd)
            chk($sformatf("vec%0d_rdata", i), 32'(got_rd), 32'(vecs[i].exp_rd));
      end
      chk("irq_after_table", 32'(io_irq), 32'd1);

      // Interrupt aggregation, lag and W1C interplay
      transact(16'hC000, 0, 2'b01, 16'h0008, -1, 16'h0000, got_rd, got_lat);
      tick();
      chk("irq_cleared", 32'(io_irq), 32'd0);
      tgt_irq = 3'b010;
      tick(); tick();
      chk("irq_masked_src", 32'(io_irq), 32'd0);
      tgt_irq = 3'b011;
      chk("irq_lag_before", 32'(io_irq), 32'd0);
      tick();
      chk("irq_lag_after", 32'(io_irq), 32'd1);
      tgt_irq = 3'b101;
      transact(16'hC000, 1, 2'b11, 16'h0000, -1, 16'h0000, got_rd, got_lat);
      chk("irq_pend_live", 32'(got_rd), 32'h0005);
      transact(16'h8000, 1, 2'b11, 16'h0000, -1, 16'h0000, got_rd, got_lat);
      tgt_irq = 3'b000;
      tick(); tick();
      chk("irq_held_by_timeout", 32'(io_irq), 32'd1);
      tgt_irq = 3'b001;
      transact(16'hC000, 0, 2'b01, 16'h0008, -1, 16'h0000, got_rd, got_lat);
      tick();
      chk("irq_w1c_src_high", 32'(io_irq), 32'd1);
      tgt_irq = 3'b000;
      tick();
      chk("irq_w1c_src_low", 32'(io_irq), 32'd0);

      // Enable held long after acknowledge
      io_address = 16'h0123; io_rw = 1'b1; io_byte_enable = 2'b11; io_bus_enable = 1'b1;
      episodes = 0; acks = 0; prev_sel = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (tgt_sel != 3'b000 && !prev_sel) episodes++;
         prev_sel = (tgt_sel != 3'b000);
         if (io_acknowledge) acks++;
         tgt_ack = tgt_sel;
      end
      io_bus_enable = 1'b0; tgt_ack = 3'b000;
      tick(); tick();
      chk("held_enable_episodes", 32'(episodes), 32'd1);
      chk("held_enable_acks", 32'(acks), 32'd1);

      // Reset in the middle of a target access
      io_address = 16'h8044; io_rw = 1'b1; io_bus_enable = 1'b1;
      tick(); tick(); tick();
      chk("pre_reset_sel", 32'(tgt_sel), 32'h4);
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_sel", 32'(tgt_sel), 32'd0);
      chk("async_reset_ack", 32'(io_acknowledge), 32'd0);
      io_bus_enable = 1'b0;
      m_mask = 4'h0; m_pend = 1'b0; m_to_addr = 16'h0000;
      acks = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (io_acknowledge) acks++;
      end
      @(negedge clk) reset_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (io_acknowledge || tgt_sel != 3'b000) acks++;
      end
      chk("reset_no_ack", 32'(acks), 32'd0);
      transact(16'h8044, 1, 2'b11, 16'h0000, 2, 16'h3C3C, got_rd, got_lat);
      chk("post_reset_latency", 32'(got_lat), 32'd4);
      chk("post_reset_rdata", 32'(got_rd), 32'h3C3C);
      transact(16'hC001, 1, 2'b11, 16'h0000, -1, 16'h0000, got_rd, got_lat);
      chk("post_reset_mask", 32'(got_rd), 32'h0000);

      // Randomized accesses against the model
      for (int i = 0; i < 150; i++) begin
         r_region = $urandom_range(0, 3);
         r_rw     = 1'($urandom);
         r_be     = 2'($urandom);
         r_wdata  = 16'($urandom);
         r_trdata = 16'($urandom);
         if (r_region == 3) r_addr = {2'b11, 12'h000, 2'($urandom)};
         else               r_addr = {2'(r_region), 14'($urandom)};
         r_pick  = $urandom_range(0, 9);
         if (r_pick == 0)      r_delay = -1;
         else if (r_pick <= 2) r_delay = $urandom_range(T - 1, T + 2);
         else                  r_delay = $urandom_range(0, 4);
         tgt_irq = 3'($urandom);
         if (r_region == 3)           r_exp_rd = r_rw ? model_read(r_addr[1:0]) : 16'h0000;
         else if (times_out(r_delay)) r_exp_rd = 16'hDEAD;
         else                         r_exp_rd = r_trdata;
         r_exp_lat = exp_latency(r_addr, r_delay);
         transact(r_addr, r_rw, r_be, r_wdata, r_delay, r_trdata, got_rd, got_lat);
         chk("rnd_latency", 32'(got_lat), 32'(r_exp_lat));
         if (r_rw) chk("rnd_rdata", 32'(got_rd), 32'(r_exp_rd));
         chk("rnd_irq", 32'(io_irq), 32'(model_irq()));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/io_bus_target_ctrl.md
# io_bus_target_ctrl

Address-decoding transaction controller on the FPGA side of the HPS external I/O bus (the 16-bit `io_*` bridge port of the top-level system). Shares the single bridge transaction between three external target peripherals plus an internal register bank, sequences each access with a one-hot select/acknowledge handshake, and terminates hung accesses with a timeout. Aggregates target interrupts into the single `io_irq` line under a mask.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: cycles `tgt_sel` may stay high without `tgt_ack` before forced termination (1..65535).
- `TIMEOUT_RDATA`, 16'hDEAD: read data returned on a timed-out read.

Ports:
- `clk`  in  1  single system clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `io_address`  in  16  bridge address; [15:14] selects region, [13:0] is the offset.
- `io_bus_enable`  in  1  held high with stable address/data/rw/byte_enable until acknowledge.
- `io_rw`  in  1  1 = read, 0 = write.
- `io_byte_enable`  in  2  byte lanes; [0] = bits 7:0.
- `io_write_data`  in  16  write data.
- `io_read_data`  out  16  registered read data, valid in the `io_acknowledge` cycle.
- `io_acknowledge`  out  1  one-cycle completion pulse.
- `io_irq`  out  1  registered OR of masked pending interrupts.
- `tgt_sel`  out  3  one-hot target select, held for the whole target access.
- `tgt_address`  out  14  `io_address[13:0]`, registered at access start.
- `tgt_rw`, `tgt_byte_enable`, `tgt_write_data`  out  1/2/16  registered copies of the bridge fields.
- `tgt_read_data`  in  48  target i read data at [16i+15:16i].
- `tgt_ack`  in  3  per-target completion pulse.
- `tgt_irq`  in  3  per-target level interrupt, synchronous to `clk`.

## Operation
- Regions: `io_address[15:14]` 00/01/10 select targets 0/1/2; 11 selects the internal register bank.
- FSM states:
  - IDLE: on `io_bus_enable` = 1, latch the fields. A target region goes to ACCESS; region 11 performs the register read/write and goes to ACK.
  - ACCESS: `tgt_sel` bit set, timeout counter runs. `tgt_ack` on the selected bit latches `tgt_read_data` and goes to ACK. Counter reaching `TIMEOUT_CYCLES` latches `TIMEOUT_RDATA` (reads) or discards (writes), sets `TO_PEND`, captures `TO_ADDR`, and goes to ACK.
  - ACK: `io_acknowledge` = 1 for one cycle, `tgt_sel` = 0; goes to RELEASE.
  - RELEASE: waits for `io_bus_enable` = 0, then goes to IDLE. A held enable never starts a second access.
- `tgt_ack` on a non-selected bit, or outside ACCESS, is ignored.
- Register bank, word offsets in `io_address[1:0]`; offsets 3 and above read 0 and ignore writes:
  - 0 `IRQ_PEND`: bits 2:0 = live `tgt_irq` (read-only); bit 3 = `TO_PEND`, sticky, write-1-to-clear via `byte_enable[0]`.
  - 1 `IRQ_MASK`: bits 3:0 RW, resets to 0.
  - 2 `TO_ADDR`: RO, full 16-bit address of the last timed-out access.
- Internal register writes honour byte enables per lane.
- `io_irq` is registered: `|({TO_PEND, tgt_irq} & IRQ_MASK)`.
- Timeout counter is 16 bits, cleared on ACCESS entry; no wrap is possible.

## Timing
- Reset values: all outputs 0, FSM in IDLE, `IRQ_MASK` = 0, `TO_PEND` = 0, `TO_ADDR` = 0.
- Let cycle n be the first cycle `io_bus_enable` is sampled high in IDLE.
  - Internal register access: `io_acknowledge` in cycle n+1.
  - Target access: `tgt_sel` high from cycle n+1. If `tgt_ack` is sampled in cycle m, `io_acknowledge` is high in cycle m+1 and `tgt_sel` falls in cycle m+1.
  - Timeout: `io_acknowledge` in cycle n+2+`TIMEOUT_CYCLES`.
- Next access can be accepted no earlier than 2 cycles after the acknowledge cycle.
- `tgt_ack` in the same cycle the timeout expires: ack wins; no timeout is recorded.
- `TO_PEND` set and W1C clear in the same cycle: set wins.
- `io_irq` lags a `tgt_irq` or mask change by 1 cycle.
- Asserting `reset_n` mid-access: outputs drop to 0 immediately and no acknowledge is issued.

## Structure
- `io_bus_pkg`: FSM state enum, region constants (`REGION_REGS` = 2'b11), register offsets, target count (3).
- Sub-module `io_bus_regs`: mask, pending, `TO_ADDR` and IRQ reduction. The FSM, decode and counter stay in `io_bus_target_ctrl`.

## Test plan
- Reset, then read offset 1 at 16'hC001 -> `io_acknowledge` in cycle n+1, `io_read_data` = 0.
- Write 16'h1234 to 16'h4010; target 1 acks 3 cycles after select -> `tgt_sel` = 3'b010, `tgt_address` = 14'h0010, `tgt_write_data` = 16'h1234; acknowledge in the following cycle; single pulse.
- Read 16'h8000 with target 2 never acking, `TIMEOUT_CYCLES` = 8 -> acknowledge in cycle n+10 with read data 16'hDEAD; `TO_ADDR` = 16'h8000; `TO_PEND` = 1.
- Write `IRQ_MASK` = 4'b1001, raise `tgt_irq[0]` -> `io_irq` rises 1 cycle later. A prior timeout also holds `io_irq`; W1C 16'h0008 to offset 0 drops it unless `tgt_irq[0]` is still high.
- Hold `io_bus_enable` high for 6 cycles after acknowledge -> exactly one `tgt_sel` episode and one acknowledge.
- Assert `reset_n` low during ACCESS -> `tgt_sel` = 0 asynchronously, no acknowledge; the next access after reset completes normally.
